// File: rtl/tune_trig_pkg.sv
// Shared types and constants for the tune trigger: FSM state encoding and default tune length.
package tune_trig_pkg;

  typedef enum logic [1:0] {StIdle, StFire, StPlay, StGap} trig_state_t;

  localparam int unsigned TUNE_LEN_FAST = 32'd1 << 22;
  localparam int unsigned TUNE_LEN_SLOW = 32'd1 << 26;
  localparam int unsigned TUNE_MARGIN   = 32'd64;

  // Busy time covering one whole tune of the player built with the same fast_sim setting.
  function automatic int unsigned default_busy(input int unsigned fast_sim);
    return ((fast_sim != 0) ? TUNE_LEN_FAST : TUNE_LEN_SLOW) + TUNE_MARGIN;
  endfunction

endpackage

// File: rtl/tune_trigger_if.sv
// Trigger-side and player-side signals of the tune trigger, bundled for port lists.
interface tune_trigger_if;
  logic       trig_raw;
  logic       clr_pend;
  logic       go;
  logic       busy;
  logic [3:0] pending;
  logic       ovf;

  modport master (output trig_raw, output clr_pend,
                  input go, input busy, input pending, input ovf);
  modport slave  (input trig_raw, input clr_pend,
                  output go, output busy, output pending, output ovf);
endinterface

// File: rtl/trig_cond.sv
// Trigger conditioning: 2-flop synchronizer, optional debouncer, rising-edge detect.
// Debouncer is built only when TUNE_TRIG_DEBOUNCE_EN is defined.
module trig_cond #(
`ifdef TUNE_TRIG_DEBOUNCE_EN
  parameter int unsigned DEB_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_raw_i,
  output logic rise_o
);

  logic s1_q, s2_q, prev_q, level;

  // Flops reset high so a trigger held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= trig_raw_i;
      s2_q <= s1_q;
    end
  end

`ifdef TUNE_TRIG_DEBOUNCE_EN
  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

  logic            filt_q;
  logic [DebW-1:0] deb_cnt_q;

  // Any break in the mismatch restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q    <= 1'b1;
      deb_cnt_q <= '0;
    end else if (s2_q != filt_q) begin
      if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
        filt_q    <= s2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end else begin
      deb_cnt_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = s2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= level;
  end

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/tune_trigger.sv
// Paces trigger requests into single-cycle go pulses, one per tune, with queued requests.
// Optional input debouncer: define TUNE_TRIG_DEBOUNCE_EN.
module tune_trigger
  import tune_trig_pkg::*;
#(
  parameter int unsigned FAST_SIM    = 1,
  parameter int unsigned BUSY_CYCLES = default_busy(FAST_SIM),
  parameter int unsigned GAP_CYCLES  = 1024,
  parameter int unsigned PEND_MAX    = 3,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input logic           clk,
  input logic           rst,
  tune_trigger_if.slave bus
);

  if (BUSY_CYCLES < 1 || PEND_MAX < 1 || PEND_MAX > 15 || DEB_CYCLES < 1) begin : g_bad_cfg
    $error("tune_trigger: illegal parameter combination");
  end

  localparam int unsigned TimerMax = (BUSY_CYCLES > GAP_CYCLES) ? BUSY_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  trig_state_t       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              rise, dec;

  trig_cond #(
`ifdef TUNE_TRIG_DEBOUNCE_EN
    .DEB_CYCLES(DEB_CYCLES)
`endif
  ) u_cond (
    .clk       (clk),
    .rst       (rst),
    .trig_raw_i(bus.trig_raw),
    .rise_o    (rise)
  );

  assign dec = (state_q == StFire);

  // A clear wins over everything, including the decrement of the tune being fired.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (bus.clr_pend) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (rise && !dec) begin
      if (pend_q < 4'(PEND_MAX)) pend_d = pend_q + 4'd1;
      else                       ovf_d  = 1'b1;
    end else if (dec && !rise) begin
      pend_d = pend_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: if (pend_q != '0) state_d = StFire;
      StFire: begin
        timer_d = TimerW'(BUSY_CYCLES - 1);
        state_d = StPlay;
      end
      StPlay: begin
        if (timer_q == '0) begin
          if (GAP_CYCLES != 0) begin
            timer_d = TimerW'(GAP_CYCLES - 1);
            state_d = StGap;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StGap: begin
        if (timer_q == '0) state_d = StIdle;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.go      = (state_q == StFire);
  assign bus.busy    = (state_q != StIdle);
  assign bus.pending = pend_q;
  assign bus.ovf     = ovf_q;

endmodule
